// File: rtl/imem_pkg.sv
// imem_pkg: constants shared by the instruction-memory loader and the
// processor's decoder.
//   - imem geometry (IMEM_DEPTH, ADDR_W, LEN_W) and instruction width INSTR_W
//   - opcode encodings and instruction field bit positions
//   - loader FSM state enum
package imem_pkg;

  localparam int IMEM_DEPTH = 16;
  localparam int ADDR_W     = 4;
  localparam int INSTR_W    = 8;
  localparam int LEN_W      = ADDR_W + 1;

  // Length bounds in the width of the len port, so comparisons stay width-clean.
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(IMEM_DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  // Instruction fields: [7:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2
  localparam int OPC_HI = 7;
  localparam int OPC_LO = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 4;
  localparam int RS1_HI = 3;
  localparam int RS1_LO = 2;
  localparam int RS2_HI = 1;
  localparam int RS2_LO = 0;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    RUN   = 2'd3
  } state_e;

  function automatic logic [1:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader: writer-side front end for the 8-bit instruction memory.
// Accepts instruction bytes on a valid/ready stream, writes them to
// consecutive imem addresses starting at 0 and keeps the core in reset
// until the programmed length has been written.
//
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   start, len          load request and instruction count (sampled in IDLE/RUN)
//   abort               return to IDLE from any state, core stays in reset
//   in_valid, in_data   instruction byte stream
//   in_ready            loader accepts a byte this cycle (only in LOAD)
//   imem_we/addr/wdata  registered imem write port
//   core_reset, done    processor reset (low only in RUN), run indicator
//   err_len, ill_op     sticky length error / reserved-opcode flags
//   state_dbg           current FSM state, for observation
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_data is ignored whenever in_ready is low; in_valid may stay high.
module imem_loader
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               abort,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               core_reset,
  output logic               done,
  output logic               err_len,
  output logic               ill_op,
  output logic [1:0]         state_dbg
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic [INSTR_W-1:0] imem_wdata_q, imem_wdata_d;
  logic               core_reset_q, core_reset_d;
  logic               done_q, done_d;
  logic               err_len_q, err_len_d;
  logic               ill_op_q, ill_op_d;
  logic               len_ok;
  logic               last_xfer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      len_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      err_len_q    <= 1'b0;
      ill_op_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      len_q        <= len_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      err_len_q    <= err_len_d;
      ill_op_q     <= ill_op_d;
    end
  end

  assign len_ok    = (len != '0) && (len <= LEN_MAX);
  assign last_xfer = ({1'b0, count_q} == (len_q - LEN_ONE));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    len_d        = len_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    err_len_d    = err_len_q;
    ill_op_d     = ill_op_q;

    if (abort) begin
      // Abort wins over start and over a same-cycle transfer.
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (start) begin
            if (len_ok) begin
              len_d     = len;
              count_d   = '0;
              ill_op_d  = 1'b0;
              err_len_d = 1'b0;
              state_d   = LOAD;
            end else begin
              err_len_d = 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = count_q;
            imem_wdata_d = in_data;
            if (get_opcode(in_data) == OP_RSVD) ill_op_d = 1'b1;
            // Stop counting at len-1 so the address never wraps at full depth.
            if (last_xfer) state_d = DRAIN;
            else           count_d = count_q + ADDR_W'(1);
          end
        end
        DRAIN:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end

    // Derived from the next state so RUN entry/exit flips these in the same edge.
    core_reset_d = (state_d != RUN);
    done_d       = (state_d == RUN);
  end

  assign in_ready   = (state_q == LOAD);
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign err_len    = err_len_q;
  assign ill_op     = ill_op_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized stimulus for imem_loader with a
// write scoreboard (expected {addr,data} queue) and flag model.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int W = ADDR_W + INSTR_W;

  logic               clk;
  logic               reset;
  logic               start;
  logic [LEN_W-1:0]   len;
  logic               abort;
  logic               in_valid;
  logic [INSTR_W-1:0] in_data;
  logic               in_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               core_reset;
  logic               done;
  logic               err_len;
  logic               ill_op;
  logic [1:0]         state_dbg;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .err_len    (err_len),
    .ill_op     (ill_op),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  int           exp_idx;
  logic         exp_err;
  logic         exp_ill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every imem write must match the next expected {addr,data}.
  always @(negedge clk) begin
    if (!reset && imem_we === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_write", 32'(exp_q.size()), 32'd1);
      else chk("imem_write", 32'({imem_addr, imem_wdata}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    if (l >= 1 && l <= IMEM_DEPTH) begin
      exp_err = 1'b0;
      exp_ill = 1'b0;
      exp_idx = 0;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  // Present one byte after 'gap' idle cycles; returns one cycle after transfer.
  task automatic send_byte(input logic [INSTR_W-1:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'(n), 32'd0);
    exp_q.push_back({exp_idx[ADDR_W-1:0], b});
    exp_idx++;
    if (b[7:6] == 2'b11) exp_ill = 1'b1;
    @(negedge clk);
  endtask

  // Called right after the final send_byte returns.
  task automatic finish_load(input string tag);
    in_valid = 1'b0;
    chk({tag, "_drain"}, 32'(state_dbg), 32'(DRAIN));
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({tag, "_state_run"}, 32'(state_dbg), 32'(RUN));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd0);
    chk({tag, "_we_off"}, 32'(imem_we), 32'd0);
    chk({tag, "_ill_op"}, 32'(ill_op), 32'(exp_ill));
    chk({tag, "_err_len"}, 32'(err_len), 32'(exp_err));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  logic [INSTR_W-1:0] basic_bytes [3];
  int                 rl;

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0;
    exp_idx = 0; exp_err = 1'b0; exp_ill = 1'b0;
    basic_bytes[0] = 8'h0B; basic_bytes[1] = 8'h5A; basic_bytes[2] = 8'h84;

    @(negedge clk);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr_data", 32'({imem_addr, imem_wdata}), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_flags", 32'({done, err_len, ill_op}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic load, in_valid held high.
    do_start(5'd3);
    chk("basic_load_state", 32'(state_dbg), 32'(LOAD));
    for (int i = 0; i < 3; i++) send_byte(basic_bytes[i], 0);
    finish_load("basic");

    // Back-to-back reload from RUN with gaps: valid 1,0,0,1.
    do_start(5'd2);
    chk("reload_core_reset", 32'(core_reset), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    send_byte(8'h0B, 0);
    send_byte(8'h84, 2);
    finish_load("gaps");

    // Length errors from RUN stay in RUN.
    do_start(5'd0);
    chk("run_len0_err", 32'(err_len), 32'd1);
    chk("run_len0_state", 32'(state_dbg), 32'(RUN));
    chk("run_len0_done", 32'(done), 32'd1);

    // Abort back to IDLE, then length errors in IDLE.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_run_state", 32'(state_dbg), 32'(IDLE));
    chk("abort_run_core_reset", 32'(core_reset), 32'd1);
    do_start(5'd17);
    chk("len17_err", 32'(err_len), 32'd1);
    chk("len17_state", 32'(state_dbg), 32'(IDLE));
    chk("len17_ready", 32'(in_ready), 32'd0);
    do_start(5'd1);
    chk("len1_err_clear", 32'(err_len), 32'd0);
    chk("len1_state", 32'(state_dbg), 32'(LOAD));
    send_byte(8'h4C, 1);
    finish_load("len1");

    // Full depth with reserved opcodes.
    do_start(5'd16);
    for (int i = 0; i < 16; i++) send_byte(8'hC0 + 8'(i), 0);
    finish_load("full");

    // Reload then abort during the second transfer.
    do_start(5'd2);
    chk("abort_reload_core_reset", 32'(core_reset), 32'd1);
    send_byte(8'h11, 0);
    in_valid = 1'b1;
    in_data  = 8'h22;
    abort    = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_state", 32'(state_dbg), 32'(IDLE));
    chk("abort_core_reset", 32'(core_reset), 32'd1);
    chk("abort_we", 32'(imem_we), 32'd0);
    chk("abort_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("abort_no_write", 32'(imem_we), 32'd0);

    // Async reset between edges after one transfer.
    do_start(5'd4);
    send_byte(8'h33, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_state", 32'(state_dbg), 32'(IDLE));
    chk("async_we", 32'(imem_we), 32'd0);
    chk("async_addr_data", 32'({imem_addr, imem_wdata}), 32'd0);
    chk("async_core_reset", 32'(core_reset), 32'd1);
    chk("async_flags", 32'({done, err_len, ill_op, in_ready}), 32'd0);
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Randomized loads with random gaps.
    for (int r = 0; r < 6; r++) begin
      rl = $urandom_range(1, IMEM_DEPTH);
      do_start(LEN_W'(rl));
      for (int i = 0; i < rl; i++) send_byte(8'($urandom), $urandom_range(0, 2));
      finish_load("rand");
      if ($urandom_range(0, 1) == 1) begin
        do_start(LEN_W'($urandom_range(IMEM_DEPTH + 1, 31)));
        chk("rand_bad_len_err", 32'(err_len), 32'd1);
        chk("rand_bad_len_state", 32'(state_dbg), 32'(RUN));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
